// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer
//
// Builds the next scanline of sprites into a back line buffer while the front
// line buffer serves palette indices for the line currently on screen. The two
// buffers swap roles on every line_start.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   line_start  one-cycle pulse at the start of each line's blanking period
//   next_line   Y of the line to build, sampled on line_start
//   obj_addr    object table read address (data returns one cycle later)
//   obj_data    {valid, hflip, type[2:0], x[9:0], y[9:0]}
//   glyph_type  glyph selector to the ROM mux
//   glyph_row   row within the glyph
//   glyph_col   column within the glyph
//   glyph_px    combinational ROM pixel (0 = transparent)
//   pix_rd      display read strobe, one cycle per pixel
//   pix_x       display read column
//   pix_idx     registered palette index for the display
//   busy        buffer init or line build in progress
//   overrun     sticky: a build was cut short by line_start
//
// Build option: define SPRITE_HFLIP_EN to honour the object hflip bit.
//
// state | meaning
// INIT  | zeroing both line buffers, one address per cycle
// IDLE  | build finished, waiting for line_start
// FETCH | obj_addr presented for object n
// CHECK | obj_data valid, vertical hit test
// DRAW  | one glyph column per cycle into the back buffer
// NEXT  | advance to the next object or finish

module sprite_line_renderer #(
  parameter int NUM_OBJ = 16,
  parameter int LINE_W  = 640,
  parameter int IDX_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       line_start,
  input  logic [9:0]                 next_line,
  output logic [$clog2(NUM_OBJ)-1:0] obj_addr,
  input  logic [24:0]                obj_data,
  output logic [2:0]                 glyph_type,
  output logic [6:0]                 glyph_row,
  output logic [6:0]                 glyph_col,
  input  logic [IDX_W-1:0]           glyph_px,
  input  logic                       pix_rd,
  input  logic [9:0]                 pix_x,
  output logic [IDX_W-1:0]           pix_idx,
  output logic                       busy,
  output logic                       overrun
);

  localparam int              OA_W      = $clog2(NUM_OBJ);
  localparam logic [10:0]     LINE_W_X  = 11'(LINE_W);
  localparam logic [9:0]      INIT_LAST = 10'(LINE_W - 1);
  localparam logic [OA_W-1:0] OBJ_LAST  = OA_W'(NUM_OBJ - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_DRAW,
    S_NEXT
  } state_t;

  function automatic logic [6:0] glyph_w(input logic [2:0] t);
    case (t)
      3'd0:    return 7'd17;
      3'd1:    return 7'd25;
      3'd2:    return 7'd19;
      3'd3:    return 7'd23;
      3'd4:    return 7'd27;
      3'd5:    return 7'd50;
      3'd6:    return 7'd73;
      default: return 7'd8;
    endcase
  endfunction

  function automatic logic [6:0] glyph_h(input logic [2:0] t);
    case (t)
      3'd0:    return 7'd16;
      3'd1:    return 7'd16;
      3'd2:    return 7'd14;
      3'd3:    return 7'd16;
      3'd4:    return 7'd9;
      3'd5:    return 7'd9;
      3'd6:    return 7'd9;
      default: return 7'd16;
    endcase
  endfunction

  logic [IDX_W-1:0] buf0_q [LINE_W];
  logic [IDX_W-1:0] buf1_q [LINE_W];

  state_t           state_q, state_d;
  logic             sel_q, sel_d;          // 0: buf0 is front, 1: buf1 is front
  logic [9:0]       line_q, line_d;
  logic [9:0]       init_q, init_d;
  logic [9:0]       x_q, x_d;
  logic [OA_W-1:0]  n_q, n_d;
  logic [2:0]       type_q, type_d;
  logic [6:0]       row_q, row_d;
  logic [6:0]       col_q, col_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [IDX_W-1:0] pix_idx_q, pix_idx_d;

`ifdef SPRITE_HFLIP_EN
  logic             flip_q, flip_d;
`else
  logic             unused_hflip;
  assign unused_hflip = obj_data[23];
`endif

  logic             obj_valid;
  logic [2:0]       obj_type;
  logic [9:0]       obj_x;
  logic [9:0]       obj_y;
  logic [10:0]      dy;
  logic             obj_hit;
  logic [6:0]       w_last;
  logic [10:0]      px;
  logic             draw_we;
  logic             rd_in_range;
  logic [IDX_W-1:0] front_px;

  logic             we0, we1;
  logic [9:0]       wa0, wa1;
  logic [IDX_W-1:0] wd0, wd1;

  assign obj_valid = obj_data[24];
  assign obj_type  = obj_data[22:20];
  assign obj_x     = obj_data[19:10];
  assign obj_y     = obj_data[9:0];

  // 11-bit difference; the >= term rejects the wrapped case
  assign dy      = {1'b0, line_q} - {1'b0, obj_y};
  assign obj_hit = obj_valid && (line_q >= obj_y) && (dy < {4'd0, glyph_h(obj_type)});

  assign w_last  = glyph_w(type_q) - 7'd1;
  // x + col may exceed 1023 near the right edge; the extra bit keeps it from wrapping
  assign px      = {1'b0, x_q} + {4'd0, col_q};
  assign draw_we = (state_q == S_DRAW) && (glyph_px != '0) && (px < LINE_W_X);

  assign rd_in_range = ({1'b0, pix_x} < LINE_W_X);
  assign front_px    = !rd_in_range ? '0 : (sel_q ? buf1_q[pix_x] : buf0_q[pix_x]);

  assign obj_addr   = n_q;
  assign glyph_type = type_q;
  assign glyph_row  = row_q;
`ifdef SPRITE_HFLIP_EN
  assign glyph_col  = flip_q ? (w_last - col_q) : col_q;
`else
  assign glyph_col  = col_q;
`endif
  assign pix_idx    = pix_idx_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

  // Buffer write ports: build writes the back buffer, display read-and-clear
  // writes the front buffer, so each buffer sees at most one writer per cycle.
  always_comb begin
    we0 = 1'b0;
    we1 = 1'b0;
    wa0 = '0;
    wa1 = '0;
    wd0 = '0;
    wd1 = '0;
    if (state_q == S_INIT) begin
      we0 = 1'b1;
      we1 = 1'b1;
      wa0 = init_q;
      wa1 = init_q;
    end else begin
      if (draw_we) begin
        if (sel_q) begin
          we0 = 1'b1;
          wa0 = px[9:0];
          wd0 = glyph_px;
        end else begin
          we1 = 1'b1;
          wa1 = px[9:0];
          wd1 = glyph_px;
        end
      end
      if (pix_rd && rd_in_range) begin
        if (sel_q) begin
          we1 = 1'b1;
          wa1 = pix_x;
        end else begin
          we0 = 1'b1;
          wa0 = pix_x;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    line_d    = line_q;
    init_d    = init_q;
    x_d       = x_q;
    n_d       = n_q;
    type_d    = type_q;
    row_d     = row_q;
    col_d     = col_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    pix_idx_d = pix_idx_q;
`ifdef SPRITE_HFLIP_EN
    flip_d    = flip_q;
`endif

    if (state_q == S_INIT) begin
      pix_idx_d = '0;
    end else if (pix_rd) begin
      pix_idx_d = front_px;
    end

    case (state_q)
      S_INIT: begin
        busy_d = 1'b1;
        init_d = init_q + 10'd1;
        if (init_q == INIT_LAST) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
      end
      S_FETCH: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (obj_hit) begin
          type_d  = obj_type;
          row_d   = dy[6:0];
          col_d   = 7'd0;
          x_d     = obj_x;
`ifdef SPRITE_HFLIP_EN
          flip_d  = obj_data[23];
`endif
          state_d = S_DRAW;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_DRAW: begin
        if (col_q == w_last) begin
          state_d = S_NEXT;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      S_NEXT: begin
        if (n_q == OBJ_LAST) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          n_d     = n_q + OA_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_INIT;
    endcase

    // A new line always wins; an unfinished build is abandoned and flagged.
    if (line_start && (state_q != S_INIT)) begin
      sel_d   = ~sel_q;
      line_d  = next_line;
      n_d     = '0;
      busy_d  = 1'b1;
      state_d = S_FETCH;
      if (state_q != S_IDLE) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      sel_q     <= 1'b0;
      line_q    <= '0;
      init_q    <= '0;
      x_q       <= '0;
      n_q       <= '0;
      type_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      pix_idx_q <= '0;
`ifdef SPRITE_HFLIP_EN
      flip_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      line_q    <= line_d;
      init_q    <= init_d;
      x_q       <= x_d;
      n_q       <= n_d;
      type_q    <= type_d;
      row_q     <= row_d;
      col_q     <= col_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      pix_idx_q <= pix_idx_d;
`ifdef SPRITE_HFLIP_EN
      flip_q    <= flip_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (we0) begin
      buf0_q[wa0] <= wd0;
    end
    if (we1) begin
      buf1_q[wa1] <= wd1;
    end
  end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb_sprite_line_renderer
//
// Drives sprite_line_renderer with directed and random object tables, provides
// the object table memory and a synthetic glyph ROM, and keeps a line-level
// reference image of both line buffers to compare every displayed pixel.

module tb_sprite_line_renderer;

  localparam int NUM_OBJ = 16;
  localparam int LINE_W  = 640;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  next_line  = '0;
  logic [3:0]  obj_addr;
  logic [24:0] obj_data;
  logic [2:0]  glyph_type;
  logic [6:0]  glyph_row;
  logic [6:0]  glyph_col;
  logic [5:0]  glyph_px;
  logic        pix_rd     = 1'b0;
  logic [9:0]  pix_x      = '0;
  logic [5:0]  pix_idx;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  logic [24:0] tbl [NUM_OBJ];
  int          mbuf [2][LINE_W];
  int          mfront = 0;
  int          gw_tab [8] = '{17, 25, 19, 23, 27, 50, 73, 8};
  int          gh_tab [8] = '{16, 16, 14, 16, 9, 9, 9, 16};

  sprite_line_renderer #(
    .NUM_OBJ(NUM_OBJ),
    .LINE_W (LINE_W),
    .IDX_W  (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_start(line_start),
    .next_line (next_line),
    .obj_addr  (obj_addr),
    .obj_data  (obj_data),
    .glyph_type(glyph_type),
    .glyph_row (glyph_row),
    .glyph_col (glyph_col),
    .glyph_px  (glyph_px),
    .pix_rd    (pix_rd),
    .pix_x     (pix_x),
    .pix_idx   (pix_idx),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // object table with one cycle read latency
  always @(posedge clk) obj_data <= tbl[obj_addr];

  function automatic logic [5:0] rom_px(input logic [2:0] t, input logic [6:0] r, input logic [6:0] c);
    int ti, ri, ci;
    ti = int'(t);
    ri = int'(r);
    ci = int'(c);
    if ((ri * 5 + ci + ti * 3) % 6 == 0) return 6'd0;
    return 6'((ti * 8 + ri * 3 + ci) % 63 + 1);
  endfunction

  assign glyph_px = rom_px(glyph_type, glyph_row, glyph_col);

  function automatic logic [24:0] ent(input int v, input int hf, input int t, input int x, input int y);
    return {v[0], hf[0], t[2:0], x[9:0], y[9:0]};
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < LINE_W; i++) mbuf[b][i] = 0;
    mfront = 0;
  endtask

  // Paint every object crossing line L into the back image, in table order.
  task automatic model_build(input int L);
    int b, t, x, y, dy, gc, g;
    logic [24:0] e;
    b = 1 - mfront;
    for (int n = 0; n < NUM_OBJ; n++) begin
      e  = tbl[n];
      t  = int'(e[22:20]);
      x  = int'(e[19:10]);
      y  = int'(e[9:0]);
      dy = L - y;
      if (e[24] && dy >= 0 && dy < gh_tab[t]) begin
        for (int c = 0; c < gw_tab[t]; c++) begin
          gc = c;
`ifdef SPRITE_HFLIP_EN
          if (e[23]) gc = gw_tab[t] - 1 - c;
`endif
          g = int'(rom_px(3'(t), 7'(dy), 7'(gc)));
          if (g != 0 && x + c < LINE_W) mbuf[b][x + c] = g;
        end
      end
    end
  endtask

  // All tasks start and finish just after a falling edge.
  task automatic pulse_ls(input int L);
    line_start = 1'b1;
    next_line  = 10'(L);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic do_line(input int L);
    pulse_ls(L);
    mfront = 1 - mfront;
    model_build(L);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic read_px(input string tag, input int x, output int e);
    pix_rd = 1'b1;
    pix_x  = 10'(x);
    @(negedge clk);
    pix_rd = 1'b0;
    e = 0;
    if (x < LINE_W) begin
      e = mbuf[mfront][x];
      mbuf[mfront][x] = 0;
    end
    chk(tag, pix_idx, e);
  endtask

  task automatic sweep(input string tag);
    for (int x = 0; x < LINE_W; x++) begin
      pix_rd = 1'b1;
      pix_x  = 10'(x);
      @(negedge clk);
      chk(tag, pix_idx, mbuf[mfront][x]);
      mbuf[mfront][x] = 0;
    end
    pix_rd = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pix_idx", pix_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_obj_addr", obj_addr, 0);
    chk("rst_glyph_type", glyph_type, 0);
    chk("rst_glyph_row", glyph_row, 0);
    chk("rst_glyph_col", glyph_col, 0);
    rst_n = 1'b1;
    n = 0;
    while (n < 3000) begin
      // a line_start during init must be ignored
      line_start = (n == 100);
      next_line  = 10'd7;
      @(negedge clk);
      n++;
      if (n == 1) chk("init_busy", busy, 1);
      if (!busy) break;
    end
    line_start = 1'b0;
    chk("init_len", n, LINE_W);
    chk("init_no_overrun", overrun, 0);
    model_clear();
  endtask

  initial begin
    int e, L, x, y;

    for (int n = 0; n < NUM_OBJ; n++) tbl[n] = '0;
    @(negedge clk);

    do_reset();
    sweep("init_sweep");

    // single frog
    tbl[0] = ent(1, 0, 0, 100, 50);
    do_line(52);
    wait_idle("frog_build");
    do_line(300);
    read_px("frog_x101", 101, e);
    repeat (2) @(negedge clk);
    chk("pix_hold", pix_idx, e);
    read_px("pix_oob", 700, e);
    read_px("frog_x100", 100, e);
    read_px("frog_x102", 102, e);
    read_px("frog_x107", 107, e);
    sweep("frog_sweep");
    wait_idle("frog_dummy");
    chk("frog_no_overrun", overrun, 0);

    // long log clipped at the right edge
    tbl[0] = ent(1, 0, 6, 600, 10);
    do_line(10);
    wait_idle("edge_build");
    do_line(0);
    sweep("edge_sweep");
    wait_idle("edge_dummy");

    // frog under bus
    tbl[0] = '0;
    tbl[3] = ent(1, 0, 0, 200, 100);
    tbl[5] = ent(1, 0, 2, 208, 98);
    do_line(105);
    wait_idle("ovl_build");
    do_line(900);
    sweep("ovl_sweep");
    wait_idle("ovl_dummy");

    // random tables
    for (int it = 0; it < 8; it++) begin
      L = int'($urandom_range(0, 1023));
      for (int n = 0; n < NUM_OBJ; n++) begin
        y = L - int'($urandom_range(0, 20)) + 3;
        if (y < 0) y = 0;
        if (y > 1023) y = 1023;
        if ($urandom_range(0, 3) == 0) x = int'($urandom_range(560, 1023));
        else x = int'($urandom_range(0, 639));
        tbl[n] = ent(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 7)), x, y);
      end
      do_line(L);
      wait_idle("rnd_build");
      do_line(int'($urandom_range(0, 1023)));
      sweep("rnd_sweep");
      wait_idle("rnd_dummy");
    end
    chk("rnd_no_overrun", overrun, 0);

    // worst-case build cut short by the next line
    for (int n = 0; n < NUM_OBJ; n++) tbl[n] = ent(1, 0, 6, int'($urandom_range(0, 700)), 20);
    pulse_ls(20);
    repeat (998) @(negedge clk);
    chk("pre_overrun", overrun, 0);
    chk("mid_busy", busy, 1);
    pulse_ls(20);
    chk("abort_obj_addr", obj_addr, 0);
    chk("overrun_set", overrun, 1);
    chk("abort_busy", busy, 1);
    wait_idle("abort_build");
    chk("overrun_sticky", overrun, 1);

    // reset in the middle of a build clears everything
    pulse_ls(20);
    repeat (300) @(negedge clk);
    do_reset();
    for (int n = 0; n < NUM_OBJ; n++) tbl[n] = '0;
    do_line(0);
    wait_idle("clr_build0");
    sweep("clr_sweep0");
    do_line(1);
    wait_idle("clr_build1");
    sweep("clr_sweep1");

    // motorcycle with hflip at the left edge
    tbl[0] = ent(1, 1, 3, 0, 0);
    do_line(5);
    wait_idle("flip_build");
    do_line(0);
    read_px("flip_x0", 0, e);
    sweep("flip_sweep");
    wait_idle("flip_dummy");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
